mult_div_seq: RTL and testbench
===============================

Name: mult_div_seq

Overview:
Multicycle sequencer for the MULT/DIV instructions (and MULTU/DIVU when the optional feature is enabled). It iterates a shift-add multiplier or restoring divider over 32 cycles and holds the HI/LO results. Control issues a one-cycle start pulse with operands taken from A/B, then stalls on busy until done. The result feeds MemToReg (MFHI/MFLO), and div_zero feeds the exception path (EPC write).

Parameters:
DATA_W, 32, operand/result width; the iteration count equals DATA_W.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state and outputs
start  in  1  one-cycle request from Control; honoured only in IDLE
op  in  2  00 MULT, 01 DIV, 10 MULTU, 11 DIVU (bit1 only meaningful with MULDIV_UNSIGNED_EN)
a  in  DATA_W  operand rs (multiplicand / dividend), from OutA
b  in  DATA_W  operand rt (multiplier / divisor), from OutB
busy  out  1  high from the edge after start acceptance until the result edge
done  out  1  one-cycle pulse; HI/LO (or div_zero) are valid in that cycle
div_zero  out  1  high alongside done when a divide had b==0; otherwise 0
hi  out  DATA_W  MULT: product[63:32]; DIV: remainder
lo  out  DATA_W  MULT: product[31:0]; DIV: quotient

Behaviour:
- Reset (asynchronous, any state): state=IDLE, counter=0, busy=0, done=0, div_zero=0, hi=0, lo=0, internal accumulators=0.
- States: IDLE, RUN, FIXUP, DONE.
- IDLE, start=1 at edge E0:
  - Latch op, sign(a), sign(b), |a|, |b| (raw values when unsigned). State goes to RUN, counter=0, busy=1.
  - Divide with b==0: go to DONE instead. Set div_zero=1. hi/lo unchanged. done is high in the cycle after E0+1, busy is high for exactly one cycle.
- RUN: one iteration per edge, counter 0..DATA_W-1. After counter==DATA_W-1, go to FIXUP (edges E1..E32).
  - Mult: 2*DATA_W-bit accumulator, add-and-shift right on the multiplier LSB.
  - Div: restoring. Shift {rem,quot} left, trial-subtract |b|, set the quotient bit if non-negative, restore otherwise.
- FIXUP (edge E33): apply sign correction and write hi/lo, busy goes to 0, state goes to DONE.
  - Mult: negate the 64-bit product if sign(a)^sign(b).
  - Div: quotient negated if sign(a)^sign(b); remainder negated if sign(a). Truncation is toward zero.
- DONE: done=1 for exactly one cycle, then IDLE. div_zero clears when leaving DONE.
- Latency: start accepted at E0 gives done high in the cycle following E33. Total 34 edges, fixed, independent of data.
- start while busy or in DONE: ignored, with no effect on the current operation and no extra done. Control must not pulse start again before done.
- op/a/b are sampled only at E0; changes afterwards are ignored.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): lo=0x80000000, hi=0, no flag.
- hi/lo hold their values between operations and change only at FIXUP or reset.

Optional Feature:
Macro MULDIV_UNSIGNED_EN.
- Defined: op[1]=1 selects unsigned operation; magnitudes are the raw operands and sign fix-up is skipped.
- Undefined: op[1] is ignored, every operation is signed, and the unsigned datapath is not synthesised.

Decomposition:
- Package muldiv_pkg holds:
  - state encoding (IDLE=2'd0, RUN=2'd1, FIXUP=2'd2, DONE=2'd3);
  - op codes (OP_MULT, OP_DIV, OP_MULTU, OP_DIVU);
  - the ITER constant.
- One sub-module: cond_negate (parameterised width, output = neg ? -x : x). It is instantiated for operand abs and the result fix-ups.

Test Plan:
- MULT a=7, b=0xFFFFFFFD (-3) -> done in the cycle after E33; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high exactly 33 cycles.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), div_zero=0.
- DIV a=5, b=0 with prior hi=0x11, lo=0x22 -> done+div_zero after E1, hi=0x11, lo=0x22 unchanged, busy high 1 cycle.
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. Also MULT 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0.
- MULT 3*4 started; start pulsed at E5 with a=9; reset asserted at E10 -> second start ignored; after reset state IDLE, busy=done=hi=lo=0, no done pulse; next MULT 3*4 -> lo=12.
- With MULDIV_UNSIGNED_EN: MULTU 0xFFFFFFFF*2 -> hi=1, lo=0xFFFFFFFE; DIVU 0xFFFFFFFF/2 -> lo=0x7FFFFFFF, hi=1. Without it the same MULTU -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the MULT/DIV sequencer: state encoding, op codes and
// the default iteration count.
package muldiv_pkg;

    localparam int ITER = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_DIV   = 2'b01;
    localparam logic [1:0] OP_MULTU = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

endpackage

// File: rtl/cond_negate.sv
// Conditional two's-complement negation: y = neg ? -x : x.
module cond_negate
    import muldiv_pkg::*;
#(
    parameter int WIDTH = ITER
) (
    input  logic [WIDTH-1:0] x,
    input  logic             neg,
    output logic [WIDTH-1:0] y
);

    logic signed [WIDTH-1:0] x_s;

    assign x_s = x;
    assign y   = neg ? WIDTH'(-x_s) : x;

endmodule

// File: rtl/mult_div_seq.sv
// Multicycle shift-add multiplier / restoring divider producing HI/LO.
// Define MULDIV_UNSIGNED_EN to honour op[1] (MULTU/DIVU); otherwise all ops are signed.
module mult_div_seq
    import muldiv_pkg::*;
#(
    parameter int DATA_W = ITER
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    state_t                state, state_nx;
    logic [CNT_W-1:0]      cnt;
    logic [2*DATA_W-1:0]   acc;
    logic [DATA_W-1:0]     opnd;
    logic                  is_div, neg_res, neg_rem, dz_pend, dz_flag;

    logic                  is_unsigned, sign_a, sign_b, b_zero;
    logic signed [DATA_W-1:0] a_s, b_s;
    logic [DATA_W-1:0]     abs_a, abs_b;

`ifdef MULDIV_UNSIGNED_EN
    assign is_unsigned = op[1];
`else
    logic unused_op_hi;
    assign unused_op_hi = op[1];
    assign is_unsigned  = 1'b0;
`endif

    assign a_s    = a;
    assign b_s    = b;
    assign sign_a = ~is_unsigned & (a_s < 0);
    assign sign_b = ~is_unsigned & (b_s < 0);
    assign b_zero = (b == '0);

    cond_negate #(.WIDTH(DATA_W)) u_abs_a (.x(a), .neg(sign_a), .y(abs_a));
    cond_negate #(.WIDTH(DATA_W)) u_abs_b (.x(b), .neg(sign_b), .y(abs_b));

    // Multiply step: conditionally add the multiplicand to the upper half, shift right
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_step;

    assign mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_step = {mul_sum, acc[DATA_W-1:1]};

    // Divide step: the shifted remainder needs one extra bit before the trial subtract
    logic [DATA_W:0]     div_r;
    logic [DATA_W+1:0]   div_diff;
    logic                div_ok;
    logic [2*DATA_W-1:0] div_step;

    assign div_r    = acc[2*DATA_W-1:DATA_W-1];
    assign div_diff = {1'b0, div_r} - {2'b00, opnd};
    assign div_ok   = ~div_diff[DATA_W+1];
    assign div_step = {div_ok ? div_diff[DATA_W-1:0] : div_r[DATA_W-1:0],
                       acc[DATA_W-2:0], div_ok};

    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quot_fix, rem_fix;

    cond_negate #(.WIDTH(2*DATA_W)) u_fix_prod (.x(acc), .neg(neg_res), .y(prod_fix));
    cond_negate #(.WIDTH(DATA_W)) u_fix_quot (.x(acc[DATA_W-1:0]), .neg(neg_res), .y(quot_fix));
    cond_negate #(.WIDTH(DATA_W)) u_fix_rem (.x(acc[2*DATA_W-1:DATA_W]), .neg(neg_rem), .y(rem_fix));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (op[0] && b_zero) ? DONE : RUN;
            RUN:     if (cnt == LAST) state_nx = FIXUP;
            FIXUP:   state_nx = DONE;
            DONE:    state_nx = dz_pend ? DONE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A divide by zero spends one busy cycle in DONE (dz_pend) before presenting done
    always_comb begin
        busy     = (state == RUN) || (state == FIXUP) || ((state == DONE) && dz_pend);
        done     = (state == DONE) && !dz_pend;
        div_zero = dz_flag;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz_pend <= 1'b0;
            dz_flag <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt     <= '0;
                        is_div  <= op[0];
                        neg_res <= sign_a ^ sign_b;
                        neg_rem <= sign_a;
                        dz_pend <= op[0] & b_zero;
                        if (op[0]) begin
                            acc  <= {{DATA_W{1'b0}}, abs_a};
                            opnd <= abs_b;
                        end else begin
                            acc  <= {{DATA_W{1'b0}}, abs_b};
                            opnd <= abs_a;
                        end
                    end
                end
                RUN: begin
                    acc <= is_div ? div_step : mul_step;
                    cnt <= cnt + 1'b1;
                end
                FIXUP: begin
                    hi <= is_div ? rem_fix  : prod_fix[2*DATA_W-1:DATA_W];
                    lo <= is_div ? quot_fix : prod_fix[DATA_W-1:0];
                end
                DONE: begin
                    if (dz_pend) begin
                        dz_pend <= 1'b0;
                        dz_flag <= 1'b1;
                    end else begin
                        dz_flag <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_seq.sv
// Scoreboard bench for mult_div_seq: directed corner cases, randomized ops,
// mid-operation start pokes and an abort by reset.
module tb_mult_div_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    always #5 clk = ~clk;

    mult_div_seq #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_mis = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on 64-bit integers; HI/LO persist across a divide by zero
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        bit          uns;
        longint      sx, sy, sq, sr;
        logic [63:0] p;
`ifdef MULDIV_UNSIGNED_EN
        uns = o[1];
`else
        uns = 1'b0;
`endif
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.dz = 1'b0;
        if (!o[0]) begin
            if (uns) p = {32'b0, x} * {32'b0, y};
            else     p = sx * sy;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (y == 0) begin
            e.hi = m_hi;
            e.lo = m_lo;
            e.dz = 1'b1;
        end else if (uns) begin
            e.lo = x / y;
            e.hi = x % y;
        end else begin
            sq = sx / sy;
            sr = sx % sy;
            e.lo = sq[31:0];
            e.hi = sr[31:0];
        end
        m_hi = e.hi;
        m_lo = e.lo;
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && done) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_mis++;
                $display("FAIL spurious_done: done=1 with no operation outstanding");
            end else begin
                e = sb.pop_front();
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
                chk("div_zero", div_zero, e.dz);
            end
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit poke);
        int   n, bc;
        bit   got;
        exp_t e;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        e = model(o, x, y);
        sb.push_back(e);
        n = 0; bc = 0; got = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start = 1'b0;
                a = $urandom; b = $urandom; op = 2'($urandom);
            end
            if (poke && n == 5) start = 1'b1;
            if (poke && n == 6) start = 1'b0;
            if (busy) bc++;
            if (done) got = 1;
        end
        chk("latency", n, e.dz ? 2 : 34);
        chk("busy_cycles", bc, e.dz ? 1 : 33);
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [31:0] rnd();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 15));
            1:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            2:       return 32'h8000_0000 | 32'($urandom_range(0, 1));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_div_zero", div_zero, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 0);
        run_op(2'b01, 32'hFFFF_FFF9, 32'd2, 1);
        run_op(2'b01, 32'h0000_2211, 32'h0000_0100, 0);
        run_op(2'b01, 32'd5, 32'd0, 1);
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(2'b10, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(2'b11, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(2'b01, 32'd100, 32'hFFFF_FFF9, 0);

        for (int i = 0; i < 30; i++)
            run_op(2'($urandom), rnd(), rnd(), bit'($urandom_range(0, 1)));

        // Abort a MULT by reset; an extra start mid-run must be ignored
        @(negedge clk);
        op = 2'b00; a = 32'd3; b = 32'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        a = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        m_hi = '0;
        m_lo = '0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        run_op(2'b00, 32'd3, 32'd4, 0);
        run_op(2'b01, 32'd9, 32'd0, 0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
